systolic_matmul_array: RTL and testbench

- Parameterised output-stationary systolic array that computes Z = X × Y for unsigned integer matrices.
- One processing element (PE) per output element: X_ROW × Y_COL PEs.
- Operands arrive as flat packed buses. The result is returned as a flat packed bus with a start/done handshake.
- Sits as a self-contained matrix-multiply accelerator under a controller that drives start and waits for done.

---
 rtl/systolic_matmul_array.sv | 186 ++++++++++++++++++
 tb/tb_systolic_matmul_array.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_matmul_array.sv
// Output-stationary systolic matrix multiplier, Z = X * Y, start/done handshake.
// Optional macro SYSTOLIC_SIGNED_EN selects two's-complement operands.
module systolic_matmul_array #(
  parameter int BITWIDTH                 = 8,
  parameter int IS_BITWIDTH_DOUBLE_SCALE = 0,
  parameter int X_ROW                    = 3,
  parameter int XCOL_YROW                = 3,
  parameter int Y_COL                    = 3
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic start,
  output logic done,
  input  logic [BITWIDTH*X_ROW*XCOL_YROW-1:0] X,
  input  logic [BITWIDTH*XCOL_YROW*Y_COL-1:0] Y,
  output logic [BITWIDTH*(IS_BITWIDTH_DOUBLE_SCALE+1)*X_ROW*Y_COL-1:0] Z
);

  localparam int BW   = BITWIDTH;
  localparam int M    = X_ROW;
  localparam int K    = XCOL_YROW;
  localparam int N    = Y_COL;
  localparam int OW   = BW * (IS_BITWIDTH_DOUBLE_SCALE + 1);
  localparam int PW   = 2 * BW;
  localparam int AW   = PW + $clog2(K);
  // Feed window is M+K+N-2 steps; one extra step drains the product register.
  localparam int LAST = M + K + N - 2;
  localparam int CW   = $clog2(LAST + 2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          last_step;

  logic [BW-1:0] x_q [M][K];
  logic [BW-1:0] y_q [K][N];
  logic [BW-1:0] a_edge [M];
  logic [BW-1:0] b_edge [N];
  logic [BW-1:0] a_in [M][N];
  logic [BW-1:0] b_in [M][N];
  logic [BW-1:0] a_q [M][N];
  logic [BW-1:0] b_q [M][N];
  logic [PW-1:0] p_q [M][N];
  logic [AW-1:0] acc_q [M][N];
  logic [AW-1:0] acc_d [M][N];
  logic [OW*M*N-1:0] z_q;

  function automatic logic [PW-1:0] mul(
    input logic [BW-1:0] a,
    input logic [BW-1:0] b
  );
`ifdef SYSTOLIC_SIGNED_EN
    mul = $signed(a) * $signed(b);
`else
    mul = a * b;
`endif
  endfunction

  function automatic logic [AW-1:0] ext(
    input logic [PW-1:0] p
  );
`ifdef SYSTOLIC_SIGNED_EN
    ext = AW'($signed(p));
`else
    ext = AW'(p);
`endif
  endfunction

  assign last_step = (cnt_q == CW'(LAST));

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE and DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = COMPUTE;
      COMPUTE: if (last_step) state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Step counter across the compute window
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                cnt_q <= '0;
    else if (state_q == LOAD)   cnt_q <= '0;
    else if (state_q == COMPUTE) cnt_q <= cnt_q + 1'b1;
  end

  // Operand capture, only in LOAD
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int r = 0; r < M; r++)
        for (int k = 0; k < K; k++)
          x_q[r][k] <= '0;
      for (int k = 0; k < K; k++)
        for (int c = 0; c < N; c++)
          y_q[k][c] <= '0;
    end else if (state_q == LOAD) begin
      for (int r = 0; r < M; r++)
        for (int k = 0; k < K; k++)
          x_q[r][k] <= X[BW*(M*K - r*K - k) - 1 -: BW];
      for (int k = 0; k < K; k++)
        for (int c = 0; c < N; c++)
          y_q[k][c] <= Y[BW*(K*N - k*N - c) - 1 -: BW];
    end
  end

  // Skewed edge feed: row r lags by r steps, column c by c steps
  always_comb begin
    for (int r = 0; r < M; r++) begin
      a_edge[r] = '0;
      for (int k = 0; k < K; k++)
        if (cnt_q == CW'(r + k)) a_edge[r] = x_q[r][k];
    end
    for (int c = 0; c < N; c++) begin
      b_edge[c] = '0;
      for (int k = 0; k < K; k++)
        if (cnt_q == CW'(c + k)) b_edge[c] = y_q[k][c];
    end
  end

  for (genvar r = 0; r < M; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      if (c == 0) begin : g_a_edge
        assign a_in[r][c] = a_edge[r];
      end else begin : g_a_pass
        assign a_in[r][c] = a_q[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_in[r][c] = b_edge[c];
      end else begin : g_b_pass
        assign b_in[r][c] = b_q[r-1][c];
      end
      assign acc_d[r][c] = acc_q[r][c] + ext(p_q[r][c]);
    end
  end

  // PE grid: multiply, accumulate, forward a right and b down
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst || state_q == LOAD) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++) begin
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
          p_q[r][c]   <= '0;
          acc_q[r][c] <= '0;
        end
    end else if (state_q == COMPUTE) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++) begin
          a_q[r][c]   <= a_in[r][c];
          b_q[r][c]   <= b_in[r][c];
          p_q[r][c]   <= mul(a_in[r][c], b_in[r][c]);
          acc_q[r][c] <= acc_d[r][c];
        end
    end
  end

  // Result register, loaded with the final sums at the end of COMPUTE
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      z_q <= '0;
    end else if (state_q == COMPUTE && last_step) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          z_q[OW*(M*N - r*N - c) - 1 -: OW] <= acc_d[r][c][OW-1:0];
    end
  end

  assign done = (state_q == DONE);
  assign Z    = z_q;

endmodule

// File: tb/tb_systolic_matmul_array.sv
// Directed bench: four array shapes share one clock, reset and start.
// Covers results, latency, overflow wrap, handshake and mid-run reset.
module tb_systolic_matmul_array;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic start;
  logic done0, done1, done2, done3;

  logic [71:0]  x9, y9;
  logic [47:0]  x1;
  logic [95:0]  y1;
  logic [23:0]  y2;
  logic [71:0]  z0;
  logic [127:0] z1;
  logic [47:0]  z2;
  logic [143:0] z3;

  int checks   = 0;
  int failures = 0;
  int lat [4];
  bit dropped;

  always #5 sys_clk = ~sys_clk;

  // 3x3x3, 8-bit result
  systolic_matmul_array #(
    .BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(0),
    .X_ROW(3), .XCOL_YROW(3), .Y_COL(3)
  ) u0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .done(done0), .X(x9), .Y(y9), .Z(z0)
  );

  // 2x3 * 3x4, 16-bit result
  systolic_matmul_array #(
    .BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(1),
    .X_ROW(2), .XCOL_YROW(3), .Y_COL(4)
  ) u1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .done(done1), .X(x1), .Y(y1), .Z(z1)
  );

  // 3x3 * 3x1 matrix-vector, 16-bit result
  systolic_matmul_array #(
    .BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(1),
    .X_ROW(3), .XCOL_YROW(3), .Y_COL(1)
  ) u2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .done(done2), .X(x9), .Y(y2), .Z(z2)
  );

  // 3x3x3, 16-bit result
  systolic_matmul_array #(
    .BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(1),
    .X_ROW(3), .XCOL_YROW(3), .Y_COL(3)
  ) u3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .done(done3), .X(x9), .Y(y9), .Z(z3)
  );

  task automatic chk(
    input string        tag,
    input logic [143:0] got,
    input logic [143:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_t1();
    x9 = 72'h010203040506070809;
    y9 = 72'h030201060504090807;
    x1 = 48'h010203040506;
    y1 = 96'h010203040505060607080900;
    y2 = 24'h010203;
  endtask

  task automatic set_ff();
    x9 = '1;
    y9 = '1;
    x1 = '1;
    y1 = '1;
    y2 = '1;
  endtask

  // Raise start, hold it, and log the edge index (0 = sampling edge)
  // at which each done first rises; optionally disturb inputs mid-run.
  task automatic run_op(input bit perturb);
    logic [3:0] dn;
    for (int i = 0; i < 4; i++) lat[i] = -1;
    dropped = 1'b0;
    @(negedge sys_clk);
    start = 1'b1;
    for (int n = 0; n < 24; n++) begin
      @(posedge sys_clk);
      #1;
      dn = {done3, done2, done1, done0};
      for (int i = 0; i < 4; i++) begin
        if (dn[i] && lat[i] < 0) lat[i] = n;
        if (!dn[i] && lat[i] >= 0) dropped = 1'b1;
      end
      if (perturb && n == 2) begin
        set_t1();
        start = 1'b0;
      end
      if (perturb && n == 3) start = 1'b1;
    end
  endtask

  task automatic chk_lat(input string tag);
    chk({tag, "_lat0"}, 144'(lat[0]), 144'd9);
    chk({tag, "_lat1"}, 144'(lat[1]), 144'd9);
    chk({tag, "_lat2"}, 144'(lat[2]), 144'd7);
    chk({tag, "_lat3"}, 144'(lat[3]), 144'd9);
    chk({tag, "_held"}, 144'(dropped), 144'd0);
  endtask

  task automatic chk_t1(input string tag);
    chk({tag, "_z0"}, z0, 72'h2A241E_605142_967E66);
    chk({tag, "_z1"}, z1,
        128'h0020_0024_002A_0010_0047_0051_0060_002E);
    chk({tag, "_z2"}, z2, 48'h000E_0020_0032);
    chk({tag, "_z3"}, z3,
        144'h002A_0024_001E_0060_0051_0042_0096_007E_0066);
  endtask

  initial begin
    sys_rst = 1'b1;
    start   = 1'b0;
    x9 = '0; y9 = '0; x1 = '0; y1 = '0; y2 = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_done", {done3, done2, done1, done0}, 4'b0000);
    chk("rst_z0", z0, '0);
    chk("rst_z1", z1, '0);
    chk("rst_z2", z2, '0);
    chk("rst_z3", z3, '0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Basic products on all shapes
    set_t1();
    run_op(1'b0);
    chk_lat("t1");
    chk_t1("t1");

    @(negedge sys_clk);
    start = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("drop_done", {done3, done2, done1, done0}, 4'b0000);
    chk("drop_z0", z0, 72'h2A241E_605142_967E66);

    // All-ones operands wrap: 3*255*255 = 0x2FA03
    // Inputs and start are disturbed during COMPUTE.
    set_ff();
    run_op(1'b1);
    chk_lat("ff");
    chk("ff_z0", z0, {9{8'h03}});
    chk("ff_z1", z1, {8{16'hFA03}});
    chk("ff_z2", z2, {3{16'hFA03}});
    chk("ff_z3", z3, {9{16'hFA03}});

    @(negedge sys_clk);
    start = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("ff_drop", {done3, done2, done1, done0}, 4'b0000);

    // Reset in the middle of COMPUTE
    set_t1();
    @(negedge sys_clk);
    start = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_done", {done3, done2, done1, done0}, 4'b0000);
    chk("mid_rst_z0", z0, '0);
    chk("mid_rst_z1", z1, '0);
    chk("mid_rst_z3", z3, '0);
    start = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;

    run_op(1'b0);
    chk_lat("after_rst");
    chk_t1("after_rst");
    @(negedge sys_clk);
    start = 1'b0;
    @(posedge sys_clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
